// File: rtl/cap_sched_pkg.sv
// Shared types for the capture scheduler.
//   sched_state_e : scheduler FSM encoding, read back through sched_state
//   desc_t        : one packet descriptor, start address and exclusive end address
//   HDR_BYTES_DEF : default size of the per-record header written ahead of packet data
//   record_len    : ring bytes consumed by one record (payload rounded up to words, plus header)
package cap_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [31:0] begin_addr;
        logic [31:0] end_addr;
    } desc_t;

    localparam int HDR_BYTES_DEF = 8;

    // Wraps modulo 2**32; callers reject end <= begin separately, so the
    // wrapped value only matters for descriptors that are dropped anyway.
    function automatic logic [31:0] record_len(input desc_t d, input logic [31:0] hdr);
        logic [31:0] span;
        span = d.end_addr - d.begin_addr;
        return ((span + 32'd3) & ~32'd3) + hdr;
    endfunction

endpackage

// File: rtl/capture_scheduler_desc_fifo.sv
// desc_fifo: synchronous descriptor FIFO with show-ahead head output.
//   clk, reset      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and descriptor; ignored while full
//   pop             : read request; ignored while empty
//   head            : descriptor at the front of the queue (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored descriptors, 0..DEPTH
module desc_fifo
    import cap_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  desc_t                  push_data,
    input  logic                   pop,
    output desc_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    desc_t       mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/capture_scheduler.sv
// capture_scheduler: feeds packet descriptors one at a time to the packet copy
// engine and places each record (header + word-rounded payload) in a circular
// output ring.
// Optional feature macro: CAP_SCHED_TIMEOUT_EN adds a WAIT watchdog of TO_CYCLES
// cycles that drops the packet without signalling the engine.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   enable                : scheduling enable; rising edge in IDLE reloads wptr to ring_base
//   ring_base, ring_size  : output ring placement in bytes (word aligned)
//   desc_valid/desc_ready : descriptor handshake, transfer when both are high
//   desc_begin, desc_end  : packet byte range [begin, end)
//   eng_start             : one-cycle start pulse to the engine
//   eng_begin/end/waddr   : engine programming, held from start until done
//   eng_done              : engine completion pulse, honoured only in WAIT
//   pkt_count, drop_count : completed packets (wrapping), drops (saturating)
//   irq, irq_ack          : sticky event flag and its clear (set wins)
//   sched_state           : FSM state for CSR readback
// Handshake: a descriptor moves when desc_valid && desc_ready on a rising clk
// edge; desc_valid may be held while desc_ready is low and the offer stays put.
module capture_scheduler
    import cap_sched_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int HDR_BYTES = HDR_BYTES_DEF,
    parameter int TO_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ring_base,
    input  logic [31:0] ring_size,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_begin,
    input  logic [31:0] desc_end,
    output logic        eng_start,
    output logic [31:0] eng_begin,
    output logic [31:0] eng_end,
    output logic [31:0] eng_waddr,
    input  logic        eng_done,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        irq,
    input  logic        irq_ack,
    output logic [1:0]  sched_state
);

    localparam logic [31:0] HDR32   = 32'(HDR_BYTES);
    localparam logic [31:0] TO_LAST = 32'(TO_CYCLES - 1);

    sched_state_e state;
    sched_state_e state_nxt;

    desc_t                  fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    desc_t       hold;
    logic [31:0] len_q;
    logic [31:0] wptr;
    logic        enable_q;
    logic        ready_en;

    logic [31:0] calc_len;
    logic        calc_drop;
    logic        calc_wrap;
    logic [31:0] calc_waddr;
    logic [32:0] ring_end;
    logic [32:0] done_sum;
    logic [31:0] done_wptr;
    logic        done_evt;
    logic        drop_evt;
    logic        to_fire;

    // Keeps desc_ready low while reset is asserted and for the first cycle after.
    assign desc_ready = ready_en && !fifo_full;

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (desc_valid && desc_ready),
        .push_data ({desc_begin, desc_end}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Occupancy is only needed through full/empty here.
    logic unused_count;
    assign unused_count = ^fifo_count;

    // Ring arithmetic is done in 33 bits so a ring ending at 2**32 compares correctly.
    assign ring_end   = {1'b0, ring_base} + {1'b0, ring_size};
    assign calc_len   = record_len(hold, HDR32);
    assign calc_drop  = (hold.end_addr <= hold.begin_addr) || (calc_len > ring_size);
    assign calc_wrap  = ({1'b0, wptr} + {1'b0, calc_len}) > ring_end;
    assign calc_waddr = calc_wrap ? ring_base : wptr;
    assign done_sum   = {1'b0, wptr} + {1'b0, len_q};
    assign done_wptr  = (done_sum == ring_end) ? ring_base : done_sum[31:0];

`ifdef CAP_SCHED_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_cnt <= '0;
        else if (state == WAIT) to_cnt <= to_cnt + 32'd1;
        else to_cnt <= '0;
    end

    // Fires in the TO_CYCLES-th cycle spent in WAIT.
    assign to_fire = (state == WAIT) && (to_cnt == TO_LAST);
`else
    logic unused_to;
    assign unused_to = ^TO_LAST;
    assign to_fire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        eng_start = 1'b0;
        done_evt  = 1'b0;
        drop_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (calc_drop) begin
                    drop_evt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion arriving in the timeout cycle still counts as a completion.
                if (eng_done) begin
                    done_evt  = 1'b1;
                    state_nxt = IDLE;
                end else if (to_fire) begin
                    drop_evt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold       <= '0;
            len_q      <= '0;
            wptr       <= '0;
            enable_q   <= 1'b0;
            ready_en   <= 1'b0;
            eng_begin  <= '0;
            eng_end    <= '0;
            eng_waddr  <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            irq        <= 1'b0;
        end else begin
            enable_q <= enable;
            ready_en <= 1'b1;

            if (pop) hold <= fifo_head;

            if (state == IDLE && enable && !enable_q) wptr <= ring_base;

            // Engine programming is latched on the way into ISSUE and held
            // untouched until the next accepted descriptor.
            if (state == CALC && !calc_drop) begin
                len_q     <= calc_len;
                wptr      <= calc_waddr;
                eng_begin <= hold.begin_addr;
                eng_end   <= hold.end_addr;
                eng_waddr <= calc_waddr;
            end

            if (done_evt) begin
                wptr      <= done_wptr;
                pkt_count <= pkt_count + 32'd1;
            end

            if (drop_evt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;

            if (done_evt || drop_evt) irq <= 1'b1;
            else if (irq_ack)         irq <= 1'b0;
        end
    end

    assign sched_state = state;

endmodule
